// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Iterative multiply/divide unit with HI/LO registers for the
//            single-cycle MIPS core. MULT/MULTU use shift-add, DIV/DIVU use
//            restoring division; both take 32 RUN cycles plus one FIX cycle.
//            MTHI/MTLO write HI/LO directly without stalling.
// Revision : 1.0 - initial release
// ============================================================================
module mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  localparam logic [2:0] c_OP_MTHI = 3'b100;
  localparam logic [2:0] c_OP_MTLO = 3'b101;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Working registers. For multiply, r_acc holds {partial product, multiplier}
  // and r_mcand the multiplicand magnitude. For divide, r_acc[31:0] shifts the
  // dividend out and the quotient in, r_mcand is the divisor magnitude.
  logic [63:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_rem;
  logic [31:0] r_a_orig;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_bz;

  logic        w_idle;
  logic        w_accept;
  logic        w_signed_op;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_remd;

  // Operand decode at the accept edge: signs and magnitudes.
  always_comb begin
    w_idle      = (r_state == c_IDLE);
    w_accept    = w_idle && start && !op[2];
    w_signed_op = !op[0];
    w_sa        = w_signed_op && a[31];
    w_sb        = w_signed_op && b[31];
    w_mag_a     = w_sa ? (~a + 32'd1) : a;
    w_mag_b     = w_sb ? (~b + 32'd1) : b;
  end

  // One iteration of shift-add multiply and restoring divide.
  // The 33-bit trial remainder never exceeds 2*divisor, so bit 32 of the
  // difference is the borrow.
  always_comb begin
    w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
    w_shift = {r_rem, r_acc[31]};
    w_diff  = w_shift - {1'b0, r_mcand};
  end

  // Sign fixup applied in FIX; divide-by-zero bypasses it entirely.
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    if (r_bz) begin
      w_quot = 32'hFFFF_FFFF;
      w_remd = r_a_orig;
    end else begin
      w_quot = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
      w_remd = r_neg_r ? (~r_rem + 32'd1) : r_rem;
    end
  end

  // Control FSM, datapath iteration and HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 32'd0;
      r_rem    <= 32'd0;
      r_a_orig <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start && op == c_OP_MTHI) begin
            r_hi <= a;
          end else if (start && op == c_OP_MTLO) begin
            r_lo <= a;
          end else if (w_accept) begin
            r_state  <= c_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= 5'd31;
            r_is_div <= op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_bz     <= (b == 32'd0);
            r_a_orig <= a;
            r_rem    <= 32'd0;
            r_mcand  <= op[1] ? w_mag_b : w_mag_a;
            r_acc    <= {32'd0, (op[1] ? w_mag_a : w_mag_b)};
          end
        end
        c_RUN: begin
          if (r_is_div) begin
            if (!w_diff[32]) begin
              r_rem        <= w_diff[31:0];
              r_acc[31:0]  <= {r_acc[30:0], 1'b1};
            end else begin
              r_rem        <= w_shift[31:0];
              r_acc[31:0]  <= {r_acc[30:0], 1'b0};
            end
          end else begin
            r_acc <= {w_sum, r_acc[31:1]};
          end
          if (r_cnt == 5'd0) begin
            r_state <= c_FIX;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        c_FIX: begin
          if (r_is_div) begin
            r_hi <= w_remd;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Purpose  : Directed self-checking bench for mdu with hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  mdu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one MULT/DIV-class op and check latency, HI/LO hold, done and result.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit inj);
    logic [31:0] h0, l0;
    int nb, nhold;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    nb = 0; nhold = 0;
    @(negedge clk);
    while (busy && nb < 100) begin
      nb++;
      if (hi !== h0 || lo !== l0) nhold++;
      if (inj && nb == 5) begin
        start = 1'b1; op = 3'b100; a = 32'h5555_5555;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(nb), 64'd33);
    check({tag, "_hold"}, 64'(nhold), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI then MTLO on consecutive edges; busy never rises
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    op = 3'b101; a = 32'hCAFE_F00D;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    check("mtlo_hi", 64'(hi), 64'hDEAD_BEEF);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    run_op("multu",     3'b001, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_neg",  3'b000, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_min",  3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_op("divu",      3'b011, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    run_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_zero", 3'b011, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_zero",  3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

    // Reserved op: no busy, HI/LO untouched
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'h1111_1111; b = 32'h2222_2222;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_hi", 64'(hi), 64'hFFFF_FFF9);
    check("rsvd_lo", 64'(lo), 64'hFFFF_FFFF);

    // Reset in the middle of a MULTU aborts with no commit
    @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int nd;
      nd = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) nd++;
      end
      check("postrst_idle", 64'(nd), 64'd0);
    end
    check("postrst_hi", 64'(hi), 64'd0);
    check("postrst_lo", 64'(lo), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
